// File: rtl/imm_gen_pkg.sv
// Shared types and encodings for the RISC-V immediate generator pipeline.
// Holds the format enum, buffer occupancy enum and opcode/funct3 constants.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_ISH  = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } imm_fmt_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Purely combinational immediate decode; every format is first built as a
// 32-bit value whose bit 31 is the extension bit, then widened to XLEN.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input  logic [31:0]     i_inst,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt,
  output logic            o_bad
);

  logic [31:0] w_raw;
  logic        w_isShift;

  assign w_isShift = (i_inst[14:12] == F3_SLLI) || (i_inst[14:12] == F3_SRXI);

  always_comb begin
    w_raw = '0;
    o_fmt = FMT_NONE;
    o_bad = 1'b0;
    if (i_inst[1:0] != 2'b11) begin
      o_bad = 1'b1;
    end else begin
      case (i_inst[6:0])
        OPC_LOAD, OPC_JALR: begin
          w_raw = {{20{i_inst[31]}}, i_inst[31:20]};
          o_fmt = FMT_I;
        end
        OPC_OP_IMM: begin
          if (w_isShift) begin
            w_raw = (XLEN == 64) ? {26'b0, i_inst[25:20]} : {27'b0, i_inst[24:20]};
            o_fmt = FMT_ISH;
          end else begin
            w_raw = {{20{i_inst[31]}}, i_inst[31:20]};
            o_fmt = FMT_I;
          end
        end
        OPC_OP_IMM_32: begin
          // Word shifts only ever take a 5-bit shamt, whatever XLEN is.
          if (RV64_OPS == 0) begin
            o_bad = 1'b1;
          end else if (w_isShift) begin
            w_raw = {27'b0, i_inst[24:20]};
            o_fmt = FMT_ISH;
          end else begin
            w_raw = {{20{i_inst[31]}}, i_inst[31:20]};
            o_fmt = FMT_I;
          end
        end
        OPC_STORE: begin
          w_raw = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
          o_fmt = FMT_S;
        end
        OPC_BRANCH: begin
          w_raw = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                   i_inst[11:8], 1'b0};
          o_fmt = FMT_B;
        end
        OPC_JAL: begin
          w_raw = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                   i_inst[30:21], 1'b0};
          o_fmt = FMT_J;
        end
        OPC_LUI, OPC_AUIPC: begin
          w_raw = {i_inst[31:12], 12'b0};
          o_fmt = FMT_U;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_imm       = {XLEN{w_raw[31]}};
    o_imm[31:0] = w_raw;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decode at the input, then a 2-entry skid buffer of
// decoded payloads with valid/ready handshakes on both sides.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_code,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output imm_fmt_e        imm_fmt,
  output logic            imm_bad
);

  localparam int PW = XLEN + 4;

  logic [XLEN-1:0] w_decImm;
  imm_fmt_e        w_decFmt;
  logic            w_decBad;
  logic [PW-1:0]   w_decPayload;
  logic [PW-1:0]   w_outPayload;
  logic            w_push;
  logic            w_pop;

  logic [PW-1:0]   r_mem [2];
  logic            r_wrPtr;
  logic            r_rdPtr;
  occ_e            r_state;
  logic            r_inReady;

  imm_decode #(
    .XLEN     (XLEN),
    .RV64_OPS (RV64_OPS)
  ) u_decode (
    .i_inst (inst_code),
    .o_imm  (w_decImm),
    .o_fmt  (w_decFmt),
    .o_bad  (w_decBad)
  );

  assign w_decPayload = {w_decImm, w_decFmt, w_decBad};
  assign out_valid    = (r_state != OCC_EMPTY);
  assign in_ready     = r_inReady;
  assign w_push       = in_valid && r_inReady;
  assign w_pop        = out_valid && out_ready;

  // Occupancy FSM plus storage; in_ready is registered so it only drops
  // on the edge that makes the buffer full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= OCC_EMPTY;
      r_inReady <= 1'b0;
      r_wrPtr   <= 1'b0;
      r_rdPtr   <= 1'b0;
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= w_decPayload;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case (r_state)
        OCC_EMPTY: begin
          r_inReady <= 1'b1;
          if (w_push) r_state <= OCC_ONE;
        end
        OCC_ONE: begin
          if (w_push && !w_pop) begin
            r_state   <= OCC_FULL;
            r_inReady <= 1'b0;
          end else begin
            r_inReady <= 1'b1;
            if (w_pop && !w_push) r_state <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_pop) begin
            r_state   <= OCC_ONE;
            r_inReady <= 1'b1;
          end else begin
            r_inReady <= 1'b0;
          end
        end
        default: begin
          r_state   <= OCC_EMPTY;
          r_inReady <= 1'b1;
        end
      endcase
    end
  end

  assign w_outPayload = out_valid ? r_mem[r_rdPtr] : '0;
  assign imm_out      = w_outPayload[PW-1:4];
  assign imm_fmt      = imm_fmt_e'(w_outPayload[3:1]);
  assign imm_bad      = w_outPayload[0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives an RV32 instance and an RV64 (RV64_OPS=1) instance in lockstep and
// checks both against a queue model with an arithmetic reference decoder.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] inst_code = '0;

  logic        rdy32, val32, bad32;
  logic [31:0] imm32;
  imm_fmt_e    fmt32;
  logic        rdy64, val64, bad64;
  logic [63:0] imm64;
  imm_fmt_e    fmt64;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] modelQ[$];
  bit          armed = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .RV64_OPS(0)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .inst_code(inst_code), .out_valid(val32), .out_ready(out_ready),
    .imm_out(imm32), .imm_fmt(fmt32), .imm_bad(bad32)
  );

  imm_gen_pipe #(.XLEN(64), .RV64_OPS(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .inst_code(inst_code), .out_valid(val64), .out_ready(out_ready),
    .imm_out(imm64), .imm_fmt(fmt64), .imm_bad(bad64)
  );

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic longint signExt(input longint v, input int bits);
    longint half;
    half = 64'sd1 <<< (bits - 1);
    return (v >= half) ? v - (half <<< 1) : v;
  endfunction

  // Reference decode from the field layouts, using plain integer arithmetic.
  task automatic refDecode(input logic [31:0] w, input bit is64, input bit rv64,
                           output longint imm, output imm_fmt_e fmt, output bit bad);
    longint     x;
    logic [6:0] opc;
    logic [2:0] f3;
    bit         sh;
    x   = longint'(w);
    opc = w[6:0];
    f3  = w[14:12];
    sh  = (f3 == 3'd1) || (f3 == 3'd5);
    imm = 0;
    fmt = FMT_NONE;
    bad = 1'b0;
    if (w[1:0] != 2'b11) bad = 1'b1;
    else if (opc == OPC_LOAD || opc == OPC_JALR || (opc == OPC_OP_IMM && !sh) ||
             (opc == OPC_OP_IMM_32 && rv64 && !sh)) begin
      imm = signExt(x >>> 20, 12); fmt = FMT_I;
    end else if (opc == OPC_OP_IMM && sh) begin
      imm = is64 ? (x >>> 20) % 64'sd64 : (x >>> 20) % 64'sd32; fmt = FMT_ISH;
    end else if (opc == OPC_OP_IMM_32) begin
      if (!rv64) bad = 1'b1;
      else begin imm = (x >>> 20) % 64'sd32; fmt = FMT_ISH; end
    end else if (opc == OPC_STORE) begin
      imm = signExt((x >>> 25) * 64'sd32 + (x >>> 7) % 64'sd32, 12); fmt = FMT_S;
    end else if (opc == OPC_BRANCH) begin
      imm = signExt((x >>> 31) * 64'sd4096 + ((x >>> 7) % 64'sd2) * 64'sd2048 +
                    ((x >>> 25) % 64'sd64) * 64'sd32 + ((x >>> 8) % 64'sd16) * 64'sd2, 13);
      fmt = FMT_B;
    end else if (opc == OPC_JAL) begin
      imm = signExt((x >>> 31) * 64'sd1048576 + ((x >>> 12) % 64'sd256) * 64'sd4096 +
                    ((x >>> 20) % 64'sd2) * 64'sd2048 + ((x >>> 21) % 64'sd1024) * 64'sd2, 21);
      fmt = FMT_J;
    end else if (opc == OPC_LUI || opc == OPC_AUIPC) begin
      imm = signExt((x >>> 12) * 64'sd4096, 32); fmt = FMT_U;
    end
  endtask

  task automatic checkOutput();
    longint   eImm;
    imm_fmt_e eFmt;
    bit       eBad;
    bit       eRdy;
    eRdy = armed && (modelQ.size() < 2) && rst_n;
    checkValue("valid32", 64'(val32), 64'(modelQ.size() > 0));
    checkValue("ready32", 64'(rdy32), 64'(eRdy));
    checkValue("valid64", 64'(val64), 64'(modelQ.size() > 0));
    checkValue("ready64", 64'(rdy64), 64'(eRdy));
    if (modelQ.size() > 0) begin
      refDecode(modelQ[0], 1'b0, 1'b0, eImm, eFmt, eBad);
      checkValue("imm32", 64'(imm32), 64'(eImm) & 64'hFFFF_FFFF);
      checkValue("fmt32", 64'(fmt32), 64'(eFmt));
      checkValue("bad32", 64'(bad32), 64'(eBad));
      refDecode(modelQ[0], 1'b1, 1'b1, eImm, eFmt, eBad);
      checkValue("imm64", imm64, 64'(eImm));
      checkValue("fmt64", 64'(fmt64), 64'(eFmt));
      checkValue("bad64", 64'(bad64), 64'(eBad));
    end else if (!rst_n) begin
      checkValue("rstImm32", 64'(imm32), 64'd0);
      checkValue("rstFmt32", 64'(fmt32), 64'(FMT_NONE));
      checkValue("rstBad32", 64'(bad32), 64'd0);
      checkValue("rstImm64", imm64, 64'd0);
      checkValue("rstFmt64", 64'(fmt64), 64'(FMT_NONE));
      checkValue("rstBad64", 64'(bad64), 64'd0);
    end
  endtask

  task automatic modelEdge();
    bit doPush, doPop;
    if (!rst_n) begin
      modelQ.delete();
      armed = 1'b0;
    end else begin
      doPush = in_valid && armed && (modelQ.size() < 2);
      doPop  = (modelQ.size() > 0) && out_ready;
      if (doPop) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(inst_code);
      armed = 1'b1;
    end
  endtask

  // Called at a falling edge: check, drive, advance one cycle, land on the next falling edge.
  task automatic applyStimulus(input logic [31:0] w, input logic v, input logic r);
    checkOutput();
    inst_code = w;
    in_valid  = v;
    out_ready = r;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic resetPulse();
    checkOutput();
    rst_n = 1'b0;
    modelQ.delete();
    armed = 1'b0;
    #1;
    checkValue("rstValid32", 64'(val32), 64'd0);
    checkValue("rstValid64", 64'(val64), 64'd0);
    checkOutput();
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] genInst();
    logic [31:0] w;
    logic [6:0]  ops [9];
    int          pick;
    ops = '{OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32, OPC_STORE,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL};
    w    = $urandom;
    pick = int'($urandom_range(0, 11));
    if (pick < 9) w[6:0] = ops[pick];
    else if (pick == 9) w[1:0] = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 1) == 1) w[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
    return w;
  endfunction

  initial begin
    @(negedge clk);
    repeat (2) applyStimulus(32'hFFF0_0093, 1'b1, 1'b1);
    rst_n = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b1);
    checkValue("readyAfterReset", 64'(rdy32), 64'd1);

    applyStimulus(32'hFFF0_0093, 1'b1, 1'b1);
    checkValue("addiImm", 64'(imm32), 64'hFFFF_FFFF);
    checkValue("addiFmt", 64'(fmt32), 64'(FMT_I));
    applyStimulus(32'h0030_9093, 1'b1, 1'b1);
    checkValue("slliImm", 64'(imm32), 64'h3);
    checkValue("slliFmt", 64'(fmt32), 64'(FMT_ISH));
    applyStimulus(32'hFE00_0EE3, 1'b1, 1'b1);
    checkValue("branchImm", 64'(imm32), 64'hFFFF_FFFC);
    checkValue("branchFmt", 64'(fmt32), 64'(FMT_B));
    applyStimulus(32'hFF5F_F06F, 1'b1, 1'b1);
    checkValue("jalImm", 64'(imm32), 64'hFFFF_FFF4);
    checkValue("jalFmt", 64'(fmt32), 64'(FMT_J));
    applyStimulus(32'h8000_0037, 1'b1, 1'b1);
    checkValue("lui64Imm", imm64, 64'hFFFF_FFFF_8000_0000);
    checkValue("lui64Fmt", 64'(fmt64), 64'(FMT_U));
    applyStimulus(32'h03F0_9093, 1'b1, 1'b1);
    checkValue("slli64Imm", imm64, 64'h3F);
    checkValue("slli64Fmt", 64'(fmt64), 64'(FMT_ISH));
    applyStimulus(32'h0000_0002, 1'b1, 1'b1);
    checkValue("badLowBits", 64'(bad32), 64'd1);
    checkValue("badLowImm", 64'(imm32), 64'd0);
    applyStimulus(32'h0000_0033, 1'b1, 1'b1);
    checkValue("opRegFmt", 64'(fmt32), 64'(FMT_NONE));
    checkValue("opRegBad", 64'(bad32), 64'd0);
    applyStimulus(32'h0000_101B, 1'b1, 1'b1);
    checkValue("opImm32Bad", 64'(bad32), 64'd1);
    checkValue("opImm32Fmt64", 64'(fmt64), 64'(FMT_ISH));
    applyStimulus(32'h0, 1'b0, 1'b1);

    applyStimulus(32'h0010_0093, 1'b1, 1'b0);
    applyStimulus(32'h0020_0093, 1'b1, 1'b0);
    checkValue("bpReadyLow", 64'(rdy32), 64'd0);
    applyStimulus(32'h0030_0093, 1'b1, 1'b0);
    checkValue("bpHeadHeld", 64'(imm32), 64'd1);
    applyStimulus(32'h0030_0093, 1'b1, 1'b0);
    applyStimulus(32'h0030_0093, 1'b1, 1'b1);
    applyStimulus(32'h0030_0093, 1'b1, 1'b1);
    applyStimulus(32'h0, 1'b0, 1'b1);
    applyStimulus(32'h0, 1'b0, 1'b1);

    applyStimulus(32'h0010_0093, 1'b1, 1'b0);
    applyStimulus(32'h0020_0093, 1'b1, 1'b0);
    resetPulse();
    applyStimulus(32'h0010_0093, 1'b1, 1'b1);
    applyStimulus(32'h0, 1'b0, 1'b1);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) resetPulse();
      applyStimulus(genInst(), logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) != 0));
    end
    checkOutput();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
